collide_det: RTL and testbench
==============================

// Module: collide_det
// PURPOSE
//  Pixel-overlap collision detector, downstream of the sprite generators (me, bullet, enemy1) and beside disp_ctrl.
//  Counts per-frame overlap of sprite alpha masks during active display, then resolves hits at frame end.
//  Produces hit pulses, the score, remaining lives and game-over for the game-logic and HUD stages.
// PARAMETERS
//  SCORE_W       16   score counter width
//  LIVES_W       4    lives counter width
//  LIVES_INIT    3    lives loaded at reset (1..2^LIVES_W-1)
//  MIN_OVERLAP   4    overlapping pixels per frame needed to count a hit (glitch filter, >=1)
//  OVL_CNT_W     8    overlap counter width; MIN_OVERLAP < 2^OVL_CNT_W
//  INVINC_FRAMES 120  frames of invincibility after a player hit (only with COLLIDE_INVINC_EN)
// PORTS
//  clk             in   1        pixel clock (clk_vga domain); one clock only
//  rst             in   1        synchronous, active-high reset
//  disp_i          in   1        active-display qualifier from disp_ctrl
//  v_sync_i        in   1        vertical sync, active low
//  me_alpha_i      in   1        player sprite opaque at current pixel
//  bullet_alpha_i  in   1        bullet sprite opaque at current pixel
//  enemy1_alpha_i  in   1        enemy sprite opaque at current pixel
//  enemy_hit_o     out  1        1-cycle pulse: bullet destroyed enemy this frame
//  me_hit_o        out  1        1-cycle pulse: player lost a life this frame
//  score_o         out  SCORE_W  enemies destroyed, saturating
//  lives_o         out  LIVES_W  remaining lives
//  game_over_o     out  1        high once lives reach 0; held until rst
// BEHAVIOUR
//  - Reset: enemy_hit_o=0, me_hit_o=0, score_o=0, lives_o=LIVES_INIT, game_over_o=0, state=PLAY, counters=0.
//  - Pixel phase: each cycle with disp_i=1: be_cnt += bullet&enemy1; me_cnt += me&enemy1; both saturate at all-ones.
//  - Frame end (FE): cycle N where v_sync_i=0 and its registered copy was 1. Hit evaluation uses counts as of cycle N.
//    be_hit = be_cnt>=MIN_OVERLAP; me_ovl = me_cnt>=MIN_OVERLAP. Both counters clear at cycle N (disp_i is 0 in sync).
//    Pulses and score/lives/game_over updates are registered: visible in cycle N+1. Pulses last exactly one cycle.
//  - States: PLAY, INVINC, OVER.
//    PLAY, FE, me_ovl: lives-1, me_hit_o pulse. If lives was 1 -> OVER (game_over_o=1 at N+1), else -> INVINC with frame_cnt=INVINC_FRAMES-1.
//    INVINC, FE: me_ovl ignored (no pulse, no decrement). frame_cnt==0 -> PLAY, else frame_cnt-1.
//    OVER: all FE evaluations ignored; score/lives frozen; no pulses; left only by rst.
//  - Score: in PLAY/INVINC, be_hit at FE -> score+1 and enemy_hit_o pulse; stays at 2^SCORE_W-1 when saturated (pulse still fires).
//  - Same-frame enemy and player hit: both applied. Score increments even when the same FE drives the state to OVER.
//  - Mid-frame rst: counters clear; the partial frame after rst is evaluated normally at the next FE.
//  - v_sync_i held low: only one FE per falling edge; no repeated evaluation.
// CONFIGURATION
//  COLLIDE_INVINC_EN defined: INVINC state and frame_cnt present, behaving as above.
//  Not defined: no INVINC state. Each FE with me_ovl in PLAY decrements lives until OVER. INVINC_FRAMES is unused.
// STRUCTURE
//  header/define.v holds the state encodings COLL_ST_PLAY/COLL_ST_INVINC/COLL_ST_OVER and the default
//   SCORE_W/LIVES_W widths shared with the HUD.
//  One sub-module, ovl_cnt: saturating overlap counter with inc/clr and threshold compare. It is instantiated twice (be, me).
// TESTING
//  1. rst held 2 cycles -> score_o=0, lives_o=3, game_over_o=0, no pulses.
//  2. Frame with 5 bullet&enemy pixels, FE -> enemy_hit_o high exactly cycle N+1; score_o=1.
//  3. Frame with 3 me&enemy pixels (below MIN_OVERLAP=4), FE -> no me_hit_o, lives_o=3.
//  4. Overlap in 3 consecutive frames, macro on, INVINC_FRAMES=2 -> one me_hit_o, lives_o=2.
//     Macro off, same stimulus -> lives 3->2->1->0, game_over_o=1.
//  5. lives=1, same frame has 4 be pixels and 4 me pixels -> score+1, lives_o=0, game_over_o=1.
//     Later overlapping frames give no pulses and no changes.
//  6. score preloaded to 16'hFFFF by forcing, be_hit -> score stays 16'hFFFF, enemy_hit_o pulses.
//     rst asserted mid-frame -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/collide_det_pkg.sv
// Shared definitions for the collision detector: state encodings and default HUD-facing widths.
package collide_det_pkg;

  localparam int unsigned COLL_SCORE_W = 16;
  localparam int unsigned COLL_LIVES_W = 4;

  typedef enum logic [1:0] {
    COLL_ST_PLAY   = 2'd0,
    COLL_ST_INVINC = 2'd1,
    COLL_ST_OVER   = 2'd2
  } coll_state_e;

endpackage

// File: rtl/collide_det_ovl_cnt.sv
// Saturating per-frame overlap counter with clear and threshold compare on the registered count.
module collide_det_ovl_cnt #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned THRESH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_c = (cnt_q >= CNT_W'(THRESH));

endmodule

// File: rtl/collide_det.sv
// Sprite collision detector: counts per-frame overlaps, resolves hits, score and lives at frame end.
// Optional feature macro: COLLIDE_INVINC_EN adds post-hit invincibility frames.
module collide_det
  import collide_det_pkg::*;
#(
  parameter int unsigned SCORE_W     = COLL_SCORE_W,
  parameter int unsigned LIVES_W     = COLL_LIVES_W,
  parameter int unsigned LIVES_INIT  = 3,
  parameter int unsigned MIN_OVERLAP = 4,
  parameter int unsigned OVL_CNT_W   = 8
`ifdef COLLIDE_INVINC_EN
  ,
  parameter int unsigned INVINC_FRAMES = 120
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               disp_i,
  input  logic               v_sync_i,
  input  logic               me_alpha_i,
  input  logic               bullet_alpha_i,
  input  logic               enemy1_alpha_i,
  output logic               enemy_hit_o,
  output logic               me_hit_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [LIVES_W-1:0] lives_o,
  output logic               game_over_o
);

  coll_state_e        state_q, state_d;
  logic               v_sync_q;
  logic               enemy_hit_q, enemy_hit_d;
  logic               me_hit_q, me_hit_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               game_over_q, game_over_d;
  logic               fe_c;
  logic               be_hit_c;
  logic               me_ovl_c;

`ifdef COLLIDE_INVINC_EN
  localparam int unsigned FRAME_W = (INVINC_FRAMES > 1) ? $clog2(INVINC_FRAMES) : 1;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
`endif

  // Frame end is the falling edge of the active-low vertical sync.
  assign fe_c = v_sync_q & ~v_sync_i;

  collide_det_ovl_cnt #(
    .CNT_W  (OVL_CNT_W),
    .THRESH (MIN_OVERLAP)
  ) u_be_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (disp_i & bullet_alpha_i & enemy1_alpha_i),
    .clr_i (fe_c),
    .hit_c (be_hit_c)
  );

  collide_det_ovl_cnt #(
    .CNT_W  (OVL_CNT_W),
    .THRESH (MIN_OVERLAP)
  ) u_me_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (disp_i & me_alpha_i & enemy1_alpha_i),
    .clr_i (fe_c),
    .hit_c (me_ovl_c)
  );

  always_comb begin
    state_d     = state_q;
    enemy_hit_d = 1'b0;
    me_hit_d    = 1'b0;
    score_d     = score_q;
    lives_d     = lives_q;
    game_over_d = game_over_q;
`ifdef COLLIDE_INVINC_EN
    frame_cnt_d = frame_cnt_q;
`endif
    if (fe_c && (state_q != COLL_ST_OVER)) begin
      // Enemy hits score in any live state, even on the frame that ends the game.
      if (be_hit_c) begin
        enemy_hit_d = 1'b1;
        if (score_q != {SCORE_W{1'b1}}) begin
          score_d = score_q + SCORE_W'(1);
        end
      end
      case (state_q)
        COLL_ST_PLAY: begin
          if (me_ovl_c) begin
            me_hit_d = 1'b1;
            lives_d  = lives_q - LIVES_W'(1);
            if (lives_q == LIVES_W'(1)) begin
              state_d     = COLL_ST_OVER;
              game_over_d = 1'b1;
            end else begin
`ifdef COLLIDE_INVINC_EN
              state_d     = COLL_ST_INVINC;
              frame_cnt_d = FRAME_W'(INVINC_FRAMES - 1);
`endif
            end
          end
        end
`ifdef COLLIDE_INVINC_EN
        COLL_ST_INVINC: begin
          if (frame_cnt_q == '0) begin
            state_d = COLL_ST_PLAY;
          end else begin
            frame_cnt_d = frame_cnt_q - FRAME_W'(1);
          end
        end
`endif
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLL_ST_PLAY;
      v_sync_q    <= 1'b0;
      enemy_hit_q <= 1'b0;
      me_hit_q    <= 1'b0;
      score_q     <= '0;
      lives_q     <= LIVES_W'(LIVES_INIT);
      game_over_q <= 1'b0;
`ifdef COLLIDE_INVINC_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      v_sync_q    <= v_sync_i;
      enemy_hit_q <= enemy_hit_d;
      me_hit_q    <= me_hit_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
`ifdef COLLIDE_INVINC_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign enemy_hit_o = enemy_hit_q;
  assign me_hit_o    = me_hit_q;
  assign score_o     = score_q;
  assign lives_o     = lives_q;
  assign game_over_o = game_over_q;

endmodule

// File: tb/tb_collide_det.sv
// Directed bench for collide_det: frame-level reference model checked every cycle plus literal checkpoints.
module tb_collide_det;

  localparam int MIN_OVL   = 4;
  localparam int LIVES0    = 3;
  localparam int SCORE_MAX = 65535;
  localparam int OVL_MAX   = 255;
`ifdef COLLIDE_INVINC_EN
  localparam int INV_FR = 2;
`else
  localparam int INV_FR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        disp_i = 1'b0;
  logic        v_sync_i = 1'b1;
  logic        me_alpha_i = 1'b0;
  logic        bullet_alpha_i = 1'b0;
  logic        enemy1_alpha_i = 1'b0;
  logic        enemy_hit_o;
  logic        me_hit_o;
  logic [15:0] score_o;
  logic [3:0]  lives_o;
  logic        game_over_o;

  collide_det #(
    .SCORE_W     (16),
    .LIVES_W     (4),
    .LIVES_INIT  (3),
    .MIN_OVERLAP (4),
    .OVL_CNT_W   (8)
`ifdef COLLIDE_INVINC_EN
    ,
    .INVINC_FRAMES (2)
`endif
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .disp_i         (disp_i),
    .v_sync_i       (v_sync_i),
    .me_alpha_i     (me_alpha_i),
    .bullet_alpha_i (bullet_alpha_i),
    .enemy1_alpha_i (enemy1_alpha_i),
    .enemy_hit_o    (enemy_hit_o),
    .me_hit_o       (me_hit_o),
    .score_o        (score_o),
    .lives_o        (lives_o),
    .game_over_o    (game_over_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;
  int ehit_cnt = 0;
  int mhit_cnt = 0;

  // Reference model: frame-level bookkeeping in plain integers.
  int e_ehit, e_mhit, e_score, e_lives, e_over;
  int m_be, m_me, m_ign;
  bit prev_vs;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      e_ehit = 0; e_mhit = 0; e_score = 0; e_lives = LIVES0; e_over = 0;
      m_be = 0; m_me = 0; m_ign = 0; prev_vs = 1'b0;
    end else begin
      e_ehit = 0;
      e_mhit = 0;
      if (prev_vs && !v_sync_i) begin
        if (e_over == 0) begin
          if (m_be >= MIN_OVL) begin
            e_ehit = 1;
            if (e_score < SCORE_MAX) e_score++;
          end
          if (m_ign > 0) begin
            m_ign--;
          end else if (m_me >= MIN_OVL) begin
            e_mhit = 1;
            e_lives--;
            if (e_lives == 0) e_over = 1;
            else m_ign = INV_FR;
          end
        end
        m_be = 0;
        m_me = 0;
      end else if (disp_i) begin
        if (bullet_alpha_i && enemy1_alpha_i && m_be < OVL_MAX) m_be++;
        if (me_alpha_i && enemy1_alpha_i && m_me < OVL_MAX) m_me++;
      end
      prev_vs = v_sync_i;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("enemy_hit_o", int'(enemy_hit_o), e_ehit);
      chk("me_hit_o", int'(me_hit_o), e_mhit);
      chk("score_o", int'(score_o), e_score);
      chk("lives_o", int'(lives_o), e_lives);
      chk("game_over_o", int'(game_over_o), e_over);
      if (enemy_hit_o) ehit_cnt++;
      if (me_hit_o) mhit_cnt++;
    end
  end

  task automatic step(input logic d, input logic vs, input logic m, input logic b, input logic e);
    disp_i = d; v_sync_i = vs; me_alpha_i = m; bullet_alpha_i = b; enemy1_alpha_i = e;
    @(posedge clk);
    #1;
  endtask

  task automatic pixels(input int nbe, input int nme);
    int n;
    n = (nbe > nme) ? nbe : nme;
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, logic'(i < nme), logic'(i < nbe), 1'b1);
    end
  endtask

  task automatic tail();
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input int nbe, input int nme);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pixels(nbe, nme);
    tail();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int eh0, mh0;
    rst = 1'b1;
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    armed = 1'b1;
    chk("rst_score", int'(score_o), 0);
    chk("rst_lives", int'(lives_o), 3);
    chk("rst_game_over", int'(game_over_o), 0);
    chk("rst_pulses", int'(enemy_hit_o) + int'(me_hit_o), 0);
    rst = 1'b0;

    frame(5, 0);
    chk("be5_pulses", ehit_cnt, 1);
    chk("be5_score", int'(score_o), 1);

    frame(0, 3);
    chk("me3_no_hit", mhit_cnt, 0);
    chk("me3_lives", int'(lives_o), 3);

    frame(300, 0);
    chk("be300_score", int'(score_o), 2);

    repeat (3) frame(0, 5);
`ifdef COLLIDE_INVINC_EN
    chk("three_ovl_hits", mhit_cnt, 1);
    chk("three_ovl_lives", int'(lives_o), 2);
    chk("three_ovl_over", int'(game_over_o), 0);
`else
    chk("three_ovl_hits", mhit_cnt, 3);
    chk("three_ovl_lives", int'(lives_o), 0);
    chk("three_ovl_over", int'(game_over_o), 1);
`endif

    do_reset();
    repeat (2) begin
      frame(0, 5);
      repeat (INV_FR) frame(0, 0);
    end
    chk("pre_last_lives", int'(lives_o), 1);
    frame(4, 4);
    chk("last_score", int'(score_o), 1);
    chk("last_lives", int'(lives_o), 0);
    chk("last_over", int'(game_over_o), 1);
    eh0 = ehit_cnt;
    mh0 = mhit_cnt;
    repeat (2) frame(5, 5);
    chk("over_no_epulse", ehit_cnt - eh0, 0);
    chk("over_no_mpulse", mhit_cnt - mh0, 0);
    chk("over_score", int'(score_o), 1);
    chk("over_lives", int'(lives_o), 0);

    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    force dut.score_q = 16'hFFFF;
    e_score = SCORE_MAX;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    release dut.score_q;
    eh0 = ehit_cnt;
    pixels(5, 0);
    tail();
    chk("sat_score", int'(score_o), SCORE_MAX);
    chk("sat_pulse", ehit_cnt - eh0, 1);

    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pixels(0, 2);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    chk("midrst_score", int'(score_o), 0);
    chk("midrst_lives", int'(lives_o), 3);
    chk("midrst_over", int'(game_over_o), 0);
    pixels(0, 4);
    tail();
    chk("partial_frame_lives", int'(lives_o), 2);

    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
